// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and a
// ceiling-log2 helper used to size internal counters.
package counter_pkg;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-qualified phase counter producing a one-cycle step strobe every
// PRESCALE enabled cycles; with PRESCALE=1 the strobe follows en directly.
module cnt_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic strobe
);

  localparam int unsigned PW = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;
  logic          at_last;

  assign at_last = (phase == LAST);
  assign strobe  = en & at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (sync_clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= at_last ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, parallel load,
// synchronous clear, prescaled enable and wrap/terminal-count flags.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 2 ** WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

  logic strobe;
  logic at_max;
  logic at_min;

  // Load also restarts the prescale phase so the next step is a full period away.
  cnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync_clr(clear | load),
    .strobe  (strobe)
  );

  assign at_max = (q == QMAX);
  assign at_min = (q == '0);
  assign tc     = (up_dn == CNT_UP) ? at_max : at_min;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      q          <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      q    <= (load_val > QMAX) ? QMAX : load_val;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= strobe;
      wrap <= 1'b0;
      if (strobe) begin
        if (up_dn == CNT_UP) begin
          if (at_max) begin
            q          <= '0;
            wrap       <= 1'b1;
            ovf_sticky <= 1'b1;
          end else begin
            q <= q + WIDTH'(1);
          end
        end else begin
          if (at_min) begin
            q          <= QMAX;
            wrap       <= 1'b1;
            ovf_sticky <= 1'b1;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: two counters (MODULUS=10, PRESCALE 1 and 3) on shared
// inputs, checked by directed scenarios and a randomized run against a model.
module tb_param_updown_counter;

  localparam int MOD = 10;
  localparam int PS[2] = '{1, 3};

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] qa, qb;
  logic       tka, tkb, tca, tcb, wra, wrb, sta, stb;

  logic [3:0] dq[2];
  logic       dtk[2], dtc[2], dwr[2], dst[2];

  int mcnt[2];
  int mph[2];
  bit mwr[2], mst[2], mtk[2];

  int passed = 0;
  int total  = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .q(qa), .tick(tka), .tc(tca),
    .wrap(wra), .ovf_sticky(sta)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .q(qb), .tick(tkb), .tc(tcb),
    .wrap(wrb), .ovf_sticky(stb)
  );

  assign dq[0] = qa;   assign dq[1] = qb;
  assign dtk[0] = tka; assign dtk[1] = tkb;
  assign dtc[0] = tca; assign dtc[1] = tcb;
  assign dwr[0] = wra; assign dwr[1] = wrb;
  assign dst[0] = sta; assign dst[1] = stb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mph[k] = 0; mwr[k] = 0; mst[k] = 0; mtk[k] = 0;
    end
  endtask

  // Advance one clock; the model reads the inputs as they stood at the edge.
  task automatic cycle();
    bit s;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        mcnt[k] = 0; mph[k] = 0; mst[k] = 0; mwr[k] = 0; mtk[k] = 0;
      end else if (load) begin
        mcnt[k] = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        mph[k] = 0; mwr[k] = 0; mtk[k] = 0;
      end else begin
        s = en && (mph[k] == PS[k] - 1);
        if (en) mph[k] = (mph[k] + 1) % PS[k];
        mtk[k] = s;
        mwr[k] = 0;
        if (s) begin
          if (up_dn) begin
            if (mcnt[k] == MOD - 1) begin mwr[k] = 1; mst[k] = 1; end
            mcnt[k] = (mcnt[k] + 1) % MOD;
          end else begin
            if (mcnt[k] == 0) begin mwr[k] = 1; mst[k] = 1; end
            mcnt[k] = (mcnt[k] + MOD - 1) % MOD;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; clear = 0; load = 0; load_val = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; up_dn = 1'b0;
    idle_inputs();
    model_reset();
    #22;
    for (int k = 0; k < 2; k++) begin
      total++; if (dq[k] !== 4'd0) $display("FAIL reset_q[%0d]: got %0d want 0", k, dq[k]); else passed++;
      total++; if (dtk[k] !== 1'b0) $display("FAIL reset_tick[%0d]: got %b want 0", k, dtk[k]); else passed++;
      total++; if (dwr[k] !== 1'b0) $display("FAIL reset_wrap[%0d]: got %b want 0", k, dwr[k]); else passed++;
      total++; if (dst[k] !== 1'b0) $display("FAIL reset_sticky[%0d]: got %b want 0", k, dst[k]); else passed++;
      total++; if (dtc[k] !== 1'b1) $display("FAIL reset_tc_down[%0d]: got %b want 1", k, dtc[k]); else passed++;
    end
    #2 reset = 1'b0;
    #1;
  endtask

  task automatic test_count_up();
    idle_inputs(); up_dn = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++; if (qa !== 4'((i + 1) % 10)) $display("FAIL up_q cyc%0d: got %0d want %0d", i, qa, (i + 1) % 10); else passed++;
      total++; if (wra !== (i == 9)) $display("FAIL up_wrap cyc%0d: got %b want %b", i, wra, (i == 9)); else passed++;
      total++; if (sta !== (i >= 9)) $display("FAIL up_sticky cyc%0d: got %b want %b", i, sta, (i >= 9)); else passed++;
      total++; if (tka !== 1'b1) $display("FAIL up_tick cyc%0d: got %b want 1", i, tka); else passed++;
    end
  endtask

  task automatic test_count_down();
    idle_inputs(); up_dn = 1'b0;
    do_reset();
    #1;
    total++; if (tca !== 1'b1) $display("FAIL dn_tc_at0: got %b want 1", tca); else passed++;
    total++; if (qa !== 4'd0) $display("FAIL dn_q_start: got %0d want 0", qa); else passed++;
    en = 1'b1;
    cycle();
    total++; if (qa !== 4'd9) $display("FAIL dn_q_first: got %0d want 9", qa); else passed++;
    total++; if (wra !== 1'b1) $display("FAIL dn_wrap_first: got %b want 1", wra); else passed++;
    total++; if (tca !== 1'b0) $display("FAIL dn_tc_at9: got %b want 0", tca); else passed++;
    cycle();
    total++; if (qa !== 4'd8) $display("FAIL dn_q_second: got %0d want 8", qa); else passed++;
    total++; if (wra !== 1'b0) $display("FAIL dn_wrap_second: got %b want 0", wra); else passed++;
    total++; if (sta !== 1'b1) $display("FAIL dn_sticky: got %b want 1", sta); else passed++;
  endtask

  task automatic test_load_clamp();
    idle_inputs(); up_dn = 1'b1;
    do_reset();
    load = 1'b1; load_val = 4'd13;
    cycle();
    total++; if (qa !== 4'd9) $display("FAIL clamp_q: got %0d want 9", qa); else passed++;
    total++; if (qb !== 4'd9) $display("FAIL clamp_qb: got %0d want 9", qb); else passed++;
    total++; if (tca !== 1'b1) $display("FAIL clamp_tc: got %b want 1", tca); else passed++;
    total++; if (wra !== 1'b0) $display("FAIL clamp_wrap: got %b want 0", wra); else passed++;
    load = 1'b0; en = 1'b1;
    cycle();
    total++; if (qa !== 4'd0) $display("FAIL clamp_step_q: got %0d want 0", qa); else passed++;
    total++; if (wra !== 1'b1) $display("FAIL clamp_step_wrap: got %b want 1", wra); else passed++;
    total++; if (sta !== 1'b1) $display("FAIL clamp_step_sticky: got %b want 1", sta); else passed++;
  endtask

  task automatic test_prescale();
    idle_inputs(); up_dn = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      total++; if (qb !== 4'(i / 3)) $display("FAIL ps_q cyc%0d: got %0d want %0d", i, qb, i / 3); else passed++;
      total++; if (tkb !== (i % 3 == 0)) $display("FAIL ps_tick cyc%0d: got %b want %b", i, tkb, (i % 3 == 0)); else passed++;
    end
    cycle();
    en = 1'b0;
    cycle(); cycle();
    total++; if (qb !== 4'd3) $display("FAIL ps_hold_q: got %0d want 3", qb); else passed++;
    total++; if (tkb !== 1'b0) $display("FAIL ps_hold_tick: got %b want 0", tkb); else passed++;
    en = 1'b1;
    cycle();
    total++; if (qb !== 4'd3) $display("FAIL ps_delay_q: got %0d want 3", qb); else passed++;
    cycle();
    total++; if (qb !== 4'd4) $display("FAIL ps_delayed_step_q: got %0d want 4", qb); else passed++;
    total++; if (tkb !== 1'b1) $display("FAIL ps_delayed_step_tick: got %b want 1", tkb); else passed++;
  endtask

  task automatic test_load_clear();
    idle_inputs(); up_dn = 1'b1;
    do_reset();
    load = 1'b1; load_val = 4'd9;
    cycle();
    load = 1'b0; en = 1'b1;
    cycle();
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    cycle();
    total++; if (qa !== 4'd5) $display("FAIL lc_load5_q: got %0d want 5", qa); else passed++;
    total++; if (sta !== 1'b1) $display("FAIL lc_load_keeps_sticky: got %b want 1", sta); else passed++;
    clear = 1'b1; load_val = 4'd7;
    cycle();
    total++; if (qa !== 4'd0) $display("FAIL lc_clear_wins_q: got %0d want 0", qa); else passed++;
    total++; if (sta !== 1'b0) $display("FAIL lc_clear_sticky: got %b want 0", sta); else passed++;
    total++; if (qb !== 4'd0) $display("FAIL lc_clear_qb: got %0d want 0", qb); else passed++;
    clear = 1'b0; en = 1'b1; load_val = 4'd2;
    cycle();
    total++; if (qa !== 4'd2) $display("FAIL lc_load_vs_step_q: got %0d want 2", qa); else passed++;
    total++; if (tka !== 1'b0) $display("FAIL lc_load_vs_step_tick: got %b want 0", tka); else passed++;
    total++; if (qb !== 4'd2) $display("FAIL lc_load_qb: got %0d want 2", qb); else passed++;
    load = 1'b0;
    cycle();
    total++; if (qa !== 4'd3) $display("FAIL lc_after_load_q: got %0d want 3", qa); else passed++;
    total++; if (qb !== 4'd2) $display("FAIL lc_after_load_qb: got %0d want 2", qb); else passed++;
  endtask

  task automatic test_async_reset();
    idle_inputs(); up_dn = 1'b1;
    do_reset();
    load = 1'b1; load_val = 4'd6;
    cycle();
    load = 1'b0; en = 1'b1;
    cycle();
    total++; if (qa !== 4'd7) $display("FAIL ar_pre_q: got %0d want 7", qa); else passed++;
    total++; if (qb !== 4'd6) $display("FAIL ar_pre_qb: got %0d want 6", qb); else passed++;
    #3 reset = 1'b1;
    model_reset();
    #1;
    total++; if (qa !== 4'd0) $display("FAIL ar_async_q: got %0d want 0", qa); else passed++;
    total++; if (qb !== 4'd0) $display("FAIL ar_async_qb: got %0d want 0", qb); else passed++;
    #2 reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      total++; if (qb !== 4'(i / 3)) $display("FAIL ar_restart_qb cyc%0d: got %0d want %0d", i, qb, i / 3); else passed++;
    end
    total++; if (tkb !== 1'b1) $display("FAIL ar_restart_tick: got %b want 1", tkb); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      en       = ($urandom_range(0, 9) < 7);
      up_dn    = $urandom_range(0, 1);
      clear    = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 6);
      load_val = 4'($urandom_range(0, 15));
      cycle();
      for (int k = 0; k < 2; k++) begin
        total++; if (dq[k] !== 4'(mcnt[k])) $display("FAIL rnd_q[%0d] n%0d: got %0d want %0d", k, n, dq[k], mcnt[k]); else passed++;
        total++; if (dtk[k] !== mtk[k]) $display("FAIL rnd_tick[%0d] n%0d: got %b want %b", k, n, dtk[k], mtk[k]); else passed++;
        total++; if (dwr[k] !== mwr[k]) $display("FAIL rnd_wrap[%0d] n%0d: got %b want %b", k, n, dwr[k], mwr[k]); else passed++;
        total++; if (dst[k] !== mst[k]) $display("FAIL rnd_sticky[%0d] n%0d: got %b want %b", k, n, dst[k], mst[k]); else passed++;
        total++;
        if (dtc[k] !== (up_dn ? (mcnt[k] == MOD - 1) : (mcnt[k] == 0)))
          $display("FAIL rnd_tc[%0d] n%0d: got %b want %b", k, n, dtc[k], (up_dn ? (mcnt[k] == MOD - 1) : (mcnt[k] == 0)));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_prescale();
    test_load_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
